fetch_ctrl: RTL

Sequencing controller for the instruction-fetch stage. It owns the PC and drives a single-outstanding request/response handshake to instruction memory. It arbitrates the redirect sources (jal, jalr, taken branch) and honours a pipeline stall from the hazard unit. It delivers instr/pc_out pairs to decode, with a valid flag.

---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus for the fetch stage: a single-outstanding
// request/response handshake. The fetch controller is the master.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller.
// Owns the PC, runs a single-outstanding request/response handshake to
// instruction memory, arbitrates redirects (jalr > jal > taken branch),
// honours decode stalls and presents instr/pc_out/instr_valid to decode.
// Optional build macro MISALIGN_TRAP_EN: a redirect to a target whose low
// two bits are non-zero raises misalign_fault and parks the controller in
// FAULT until reset. Without it, target low bits are silently masked.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jal,
    input  logic               jalr,
    input  logic               branch,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic [31:0]        jalr_target,
    input  logic               stall,
    fetch_ctrl_if.master       imem,
    output logic [31:0]        instr,
    output logic [31:0]        pc_out,
`ifdef MISALIGN_TRAP_EN
    output logic               misalign_fault,
`endif
    output logic               instr_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
`ifdef MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        valid_q;
    logic        req_q;
    logic        stale_q;
`ifdef MISALIGN_TRAP_EN
    logic        fault_q;
    logic        redir_misaligned;
`endif

    logic        redir;
    logic [31:0] redir_raw;
    logic [31:0] redir_target;

    // Redirect arbitration: jalr wins, jal and taken branch share branch_target.
    always_comb begin
        redir        = jalr | jal | (branch & branch_taken);
        redir_raw    = jalr ? jalr_target : branch_target;
        redir_target = redir_raw & 32'hFFFF_FFFC;
`ifdef MISALIGN_TRAP_EN
        redir_misaligned = |redir_raw[1:0];
`endif
    end

    // Fetch FSM with registered outputs; redirects act regardless of stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            if (valid_q && !stall) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end
`ifdef MISALIGN_TRAP_EN
            if (state_q == ST_FAULT) begin
                req_q <= 1'b0;
            end else if (redir && redir_misaligned) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
                req_q   <= 1'b0;
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end else begin
`endif
            if (redir) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end
            case (state_q)
                ST_IDLE: begin
                    if (redir) begin
                        pc_q <= redir_target;
                    end
                    req_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem.imem_ready) begin
                        req_addr_q <= pc_q;
                        req_q      <= 1'b0;
                        state_q    <= ST_WAIT;
                        if (redir) begin
                            pc_q    <= redir_target;
                            stale_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end else if (redir) begin
                        pc_q <= redir_target;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (stale_q) begin
                            stale_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                            if (redir) begin
                                pc_q <= redir_target;
                            end
                        end else if (redir) begin
                            pc_q    <= redir_target;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end else begin
                            instr_q  <= imem.imem_rdata;
                            pc_out_q <= req_addr_q;
                            valid_q  <= 1'b1;
                            if (stall) begin
                                state_q <= ST_HOLD;
                            end else begin
                                req_q   <= 1'b1;
                                state_q <= ST_REQ;
                            end
                        end
                    end else if (redir) begin
                        pc_q    <= redir_target;
                        stale_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        pc_q    <= redir_target;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end else if (!stall) begin
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
`ifdef MISALIGN_TRAP_EN
            end
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign pc_out         = pc_out_q;
    assign instr_valid    = valid_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_fault = fault_q;
`endif

endmodule
